serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. It time-multiplexes one full-adder bit-slice over WIDTH cycles to add or subtract two WIDTH-bit operands. It replaces a WIDTH-stage ripple chain where area matters more than latency. Valid/ready handshakes sit on both the operand side and the result side.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  controller can accept operands (high only in IDLE).
a  input  WIDTH  operand A, sampled on input handshake.
b  input  WIDTH  operand B, sampled on input handshake.
cin  input  1  carry-in, sampled on input handshake; ignored when sub=1.
sub  input  1  1 = compute A-B, 0 = compute A+B+cin; sampled on handshake.
out_valid  output  1  result valid (high only in DONE).
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result bits.
cout  output  1  final carry-out; for sub it is the no-borrow flag (1 = A>=B unsigned).
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0, overflow=0.
  - Operand shift registers, carry flop and bit counter all cleared.
- States: IDLE, RUN, DONE, encoded as 2-bit enum.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: load a_sh=a, b_sh = sub ? ~b : b, carry = sub ? 1 : cin, bit_cnt=0, go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - Bit-slice computes s,c from a_sh[0], b_sh[0], carry.
  - sum_sh shifts right with s entering at MSB.
  - a_sh and b_sh shift right; carry<=c; bit_cnt++.
  - On the bit_cnt==WIDTH-1 cycle, also capture carry-in of that slice as msb_cin, then go to DONE.
- DONE: out_valid=1.
  - sum=sum_sh, cout=carry, overflow=msb_cin^carry.
  - On out_ready: go to IDLE.
  - sum, cout and overflow hold stable while out_valid=1 and out_ready=0 (and after DONE, until the next result overwrites them).
- Latency: handshake at edge T gives out_valid high after edge T+WIDTH. Minimum op period is WIDTH+2 cycles, because DONE->IDLE costs one cycle.
- No input acceptance in RUN/DONE; in_valid is ignored there, a/b/cin/sub need not be held.
- bit_cnt width is $clog2(WIDTH+1), so WIDTH=1 is legal: RUN lasts exactly one cycle.
- Arithmetic is modulo 2^WIDTH. The result is identical to a WIDTH-bit ripple-carry add of the same operands.
- Reset asserted mid-RUN or mid-DONE: immediate return to the IDLE reset values; the partial result is discarded and never presented.
- out_ready high in IDLE/RUN has no effect.

Decomposition:
- Package adder_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} ser_state_t.
  - localparam MAX_WIDTH=64.
- Sub-module: the team's existing full_adder cell, one instance, used as the bit-slice.
- The controller owns the FSM, shift registers, counter and carry flop.

Test Plan:
1. WIDTH=8, a=0x3C, b=0x05, cin=0, sub=0 -> sum=0x41, cout=0, overflow=0; out_valid rises exactly 9 edges after the handshake edge.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
3. sub=1, a=0x05, b=0x07, cin=1 (must be ignored) -> sum=0xFE, cout=0, overflow=0. Then sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
4. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b -> sum/cout/overflow stable, in_ready=0, no new op started. out_ready=1 -> IDLE next cycle, in_ready=1.
5. Assert rst_n=0 during RUN at bit_cnt=3 -> out_valid=0, in_ready=1 asynchronously. After release, a=0x10, b=0x20 -> sum=0x30 with correct 9-edge latency.
6. WIDTH=1 instance: a=1, b=1, cin=1 -> sum=1, cout=1, overflow=0, out_valid 2 edges after handshake. Also run 1000 random back-to-back ops against a behavioural a+b+cin model.

Source files
------------

// File: rtl/adder_pkg.sv
// ============================================================================
//  Module   : adder_pkg
//  Brief    : Shared types and limits for the bit-serial adder sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_t;

    localparam int MAX_WIDTH = 64;

endpackage : adder_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
//  Module   : full_adder
//  Brief    : One-bit full-adder cell.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
//  Module   : serial_add_ctrl
//  Brief    : Bit-serial add/subtract sequencer reusing one full-adder slice
//             over WIDTH cycles, with valid/ready on operands and result.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    ser_state_t         r_state;
    ser_state_t         w_state_next;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_bit_cnt;

    logic               w_s;
    logic               w_c;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_sh_next;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_state == RUN) && (r_bit_cnt == c_last_bit);

    full_adder u_slice (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_sum_narrow
            assign w_sum_sh_next = w_s;
        end else begin : g_sum_wide
            assign w_sum_sh_next = {w_s, r_sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand/sum shifters, carry, bit counter, result latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            r_carry   <= 1'b0;
            r_bit_cnt <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1; the caller's cin is dropped.
            r_a_sh    <= a;
            r_b_sh    <= sub ? ~b : b;
            r_carry   <= sub ? 1'b1 : cin;
            r_bit_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a_sh    <= r_a_sh >> 1;
            r_b_sh    <= r_b_sh >> 1;
            r_sum_sh  <= w_sum_sh_next;
            r_carry   <= w_c;
            r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
            if (w_last) begin
                // r_carry is the carry into the MSB slice on this final cycle.
                sum      <= w_sum_sh_next;
                cout     <= w_c;
                overflow <= r_carry ^ w_c;
            end
        end
    end

endmodule : serial_add_ctrl

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Brief    : Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       drv_valid;
    logic       rdy_d;
    logic [7:0] a_d;
    logic [7:0] b_d;
    logic       cin_d;
    logic       sub_d;

    logic       in_ready8, out_valid8, cout8, ovf8;
    logic [7:0] sum8;
    logic       in_ready1, out_valid1, cout1, ovf1;
    logic [0:0] sum1;

    logic       m_in_ready, m_out_valid, m_cout, m_ovf;
    logic [7:0] m_sum;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (drv_valid & ~sel),
        .in_ready  (in_ready8),
        .a         (a_d),
        .b         (b_d),
        .cin       (cin_d),
        .sub       (sub_d),
        .out_valid (out_valid8),
        .out_ready (rdy_d & ~sel),
        .sum       (sum8),
        .cout      (cout8),
        .overflow  (ovf8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (drv_valid & sel),
        .in_ready  (in_ready1),
        .a         (a_d[0:0]),
        .b         (b_d[0:0]),
        .cin       (cin_d),
        .sub       (sub_d),
        .out_valid (out_valid1),
        .out_ready (rdy_d & sel),
        .sum       (sum1),
        .cout      (cout1),
        .overflow  (ovf1)
    );

    assign m_in_ready  = sel ? in_ready1  : in_ready8;
    assign m_out_valid = sel ? out_valid1 : out_valid8;
    assign m_sum       = sel ? {7'b0, sum1} : sum8;
    assign m_cout      = sel ? cout1 : cout8;
    assign m_ovf       = sel ? ovf1  : ovf8;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain w-bit two's-complement add, independent of the serial datapath.
    function automatic exp_t model(input int w, input logic [7:0] aa, input logic [7:0] bb,
                                   input logic ci, input logic sb);
        exp_t       e;
        logic [8:0] mask;
        logic [8:0] ax;
        logic [8:0] bx;
        logic [8:0] full;
        mask   = (9'd1 << w) - 9'd1;
        ax     = {1'b0, aa} & mask;
        bx     = sb ? (~{1'b0, bb} & mask) : ({1'b0, bb} & mask);
        full   = ax + bx + {8'd0, (sb ? 1'b1 : ci)};
        e.sum  = full[7:0] & mask[7:0];
        e.cout = full[w];
        e.ovf  = (ax[w-1] == bx[w-1]) && (full[w-1] != ax[w-1]);
        return e;
    endfunction

    // One transaction on the selected DUT; hold = cycles to stall out_ready in DONE.
    task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input logic ci,
                          input logic sb, input int hold);
        int   w;
        int   edges;
        exp_t e;
        w = sel ? 1 : 8;
        q.push_back(model(w, aa, bb, ci, sb));

        edges = 0;
        while (!m_in_ready && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        check("in_ready_wait", m_in_ready, 1);

        a_d = aa; b_d = bb; cin_d = ci; sub_d = sb; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        a_d = 8'($urandom); b_d = 8'($urandom);
        cin_d = 1'($urandom); sub_d = 1'($urandom);

        // Edges counted inclusive of the handshake edge.
        edges = 1;
        while (!m_out_valid && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency", edges, w + 1);

        e = q.pop_front();
        check("sum", m_sum, e.sum);
        check("cout", m_cout, e.cout);
        check("overflow", m_ovf, e.ovf);

        repeat (hold) begin
            drv_valid = 1'($urandom);
            a_d = 8'($urandom);
            b_d = 8'($urandom);
            @(posedge clk); #1;
            check("hold_sum", m_sum, e.sum);
            check("hold_cout", m_cout, e.cout);
            check("hold_ovf", m_ovf, e.ovf);
            check("hold_in_ready", m_in_ready, 0);
            check("hold_out_valid", m_out_valid, 1);
        end

        drv_valid = 1'b0;
        rdy_d     = 1'b1;
        @(posedge clk); #1;
        rdy_d = 1'b0;
        check("idle_in_ready", m_in_ready, 1);
        check("idle_out_valid", m_out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; drv_valid = 1'b0; rdy_d = 1'b0;
        a_d = '0; b_d = '0; cin_d = 1'b0; sub_d = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready8", in_ready8, 1);
        check("rst_out_valid8", out_valid8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_ovf8", ovf8, 0);
        check("rst_in_ready1", in_ready1, 1);
        check("rst_out_valid1", out_valid1, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h3C, 8'h05, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'h05, 8'h07, 1'b1, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 0);
        run_op(8'hC3, 8'h5A, 1'b1, 1'b0, 5);

        // Reset in the middle of RUN, with bit_cnt at 3.
        a_d = 8'h55; b_d = 8'h22; cin_d = 1'b0; sub_d = 1'b0; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_out_valid", out_valid8, 0);
        check("midrun_in_ready", in_ready8, 1);
        check("midrun_sum", sum8, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h10, 8'h20, 1'b0, 1'b0, 0);

        repeat (100) run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);

        sel = 1'b1;
        @(posedge clk); #1;
        run_op(8'h01, 8'h01, 1'b1, 1'b0, 0);
        repeat (1000) run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);

        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_add_ctrl

`default_nettype wire
